// File: rtl/scan_linebuf_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_linebuf_ctl : shares one single-port line RAM between capture writes
//                    (2-deep stamped FIFO) and display reads. Rev 1.0
// ----------------------------------------------------------------------------
module scan_linebuf_ctl #(
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          save,
   input  logic [DW-1:0] vd,
   output logic          saved,
   input  logic          cap_line_start,
   input  logic          rd_line_start,
   input  logic          rd_req,
   output logic          rd_ack,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic [AW:0]   ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata,
   output logic          ovf
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_RD = 2'd1,
      GNT_WR = 2'd2
   } state_t;

   typedef struct packed {
      logic          bank;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   state_t        state_q, state_d;
   logic          wbank_q, wbank_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [AW-1:0] raddr_q, raddr_d;
   entry_t        fifo0_q, fifo0_d;
   entry_t        fifo1_q, fifo1_d;
   logic [1:0]    count_q, count_d;
   logic [AW:0]   ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;
   logic          ovf_q, ovf_d;
   logic          rd_cap_q, rd_cap_d;
   logic          rd_valid_q, rd_valid_d;
   logic [DW-1:0] rd_data_q, rd_data_d;

   logic          full;
   logic          accept;
   logic          drop;
   logic          wrap;
   logic          deq;
   logic [AW-1:0] waddr_base;
   logic [AW-1:0] raddr_base;
   entry_t        new_entry;
   entry_t        head;

   always_comb begin
      full       = (count_q == 2'd2);
      accept     = save && !full;
      drop       = save && full;

      // Line start is applied before stamping a same-cycle byte
      wbank_d    = wbank_q ^ cap_line_start;
      waddr_base = cap_line_start ? '0 : waddr_q;
      wrap       = accept && (waddr_base == {AW{1'b1}});
      waddr_d    = accept ? (waddr_base + AW'(1)) : waddr_base;

      new_entry.bank = wbank_d;
      new_entry.addr = waddr_base;
      new_entry.data = vd;

      raddr_base = rd_line_start ? '0 : raddr_q;

      if (full) begin
         state_d = GNT_WR;
      end else if (rd_req) begin
         state_d = GNT_RD;
      end else if ((count_q != 2'd0) || save) begin
         state_d = GNT_WR;
      end else begin
         state_d = IDLE;
      end

      // An empty FIFO lets the incoming byte bypass straight to the RAM port
      head = (count_q == 2'd0) ? new_entry : fifo0_q;
      deq  = (state_d == GNT_WR);

      fifo0_d = fifo0_q;
      fifo1_d = fifo1_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            if (accept && !deq) begin
               fifo0_d = new_entry;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (deq && accept) begin
               fifo0_d = new_entry;
            end else if (deq) begin
               count_d = 2'd0;
            end else if (accept) begin
               fifo1_d = new_entry;
               count_d = 2'd2;
            end
         end
         default: begin
            if (deq) begin
               fifo0_d = fifo1_q;
               count_d = 2'd1;
            end
         end
      endcase

      raddr_d     = raddr_base;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      case (state_d)
         GNT_WR: begin
            ram_addr_d  = {head.bank, head.addr};
            ram_wdata_d = head.data;
         end
         GNT_RD: begin
            ram_addr_d = {~wbank_q, raddr_base};
            raddr_d    = raddr_base + AW'(1);
         end
         default: begin
         end
      endcase

      ovf_d      = ovf_q || drop || wrap;
      rd_cap_d   = (state_q == GNT_RD);
      rd_valid_d = rd_cap_q;
      rd_data_d  = rd_cap_q ? ram_rdata : rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wbank_q     <= 1'b0;
         waddr_q     <= '0;
         raddr_q     <= '0;
         fifo0_q     <= '0;
         fifo1_q     <= '0;
         count_q     <= 2'd0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ovf_q       <= 1'b0;
         rd_cap_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         wbank_q     <= wbank_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         fifo0_q     <= fifo0_d;
         fifo1_q     <= fifo1_d;
         count_q     <= count_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ovf_q       <= ovf_d;
         rd_cap_q    <= rd_cap_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign ram_we    = (state_q == GNT_WR);
   assign saved     = (state_q == GNT_WR);
   assign rd_ack    = (state_q == GNT_RD);
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign ovf       = ovf_q;

endmodule
`default_nettype wire
